univ_shift_reg: RTL



---
 rtl/univ_shift_reg_pkg.sv | 13 +
 rtl/univ_shift_reg_sat_counter.sv | 40 ++++
 rtl/univ_shift_reg.sv | 81 ++++++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: the operation-select encodings.
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset, clear and an at-max flag.
module sat_counter #(
  parameter int CNT_W   = 4,
  parameter int MAX_VAL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count only ever leaves MAX_CNT through clear or reset, so at_max is sticky.
  assign at_max = (cnt_q == MAX_CNT);
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shift right/left, parallel load, shift counter with sticky done.
// Define ROTATE_EN to add the rot input, which recirculates the shifted-out bit instead of ser_in_*.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       ser_in_msb,
  input  logic                       ser_in_lsb,
`ifdef ROTATE_EN
  input  logic                       rot,
`endif
  output logic [WIDTH-1:0]           q,
  output logic                       ser_out_lsb,
  output logic                       ser_out_msb,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       done
);

  localparam int CNT_W = $clog2(WIDTH+1);

  // No handshake: mode is sampled every rising edge and the caller owns sequencing.
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             fill_msb;
  logic             fill_lsb;
  logic             shift_en;
  logic             load_en;

`ifdef ROTATE_EN
  assign fill_msb = rot ? q_q[0]       : ser_in_msb;
  assign fill_lsb = rot ? q_q[WIDTH-1] : ser_in_lsb;
`else
  assign fill_msb = ser_in_msb;
  assign fill_lsb = ser_in_lsb;
`endif

  assign shift_en = is_shift(mode);
  assign load_en  = (mode == MODE_LOAD);

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_SHR:  q_d = {fill_msb, q_q[WIDTH-1:1]};
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_lsb};
      MODE_LOAD: q_d = d;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  sat_counter #(
    .CNT_W   (CNT_W),
    .MAX_VAL (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (shift_en),
    .clear  (load_en),
    .cnt    (shift_cnt),
    .at_max (done)
  );

  // Serial outputs are taken straight from q so the pre-shift end bit is visible.
  assign q           = q_q;
  assign ser_out_lsb = q_q[0];
  assign ser_out_msb = q_q[WIDTH-1];

endmodule
